// File: rtl/uart.sv
// 8N1 serial transmitter: pulls bytes from a valid-tagged source and shifts them
// out LSB first, each bit held for CLK_PER_BIT clock cycles.
module uart #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [8:0] read_byte_out,
    output logic       read_byte_arg,
    input  logic       write_bit_out,
    output logic       write_bit_arg
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BIT_RELOAD = 16'(CLK_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    // The sink's return value carries no information for the transmitter.
    logic unused_write_bit;
    assign unused_write_bit = write_bit_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (read_byte_out[8]) begin
                    shift_d = read_byte_out[7:0];
                    cnt_d   = BIT_RELOAD;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    cnt_d   = BIT_RELOAD;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = BIT_RELOAD;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Present the next bit now so the line changes on the slot boundary.
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign read_byte_arg = (state_q == IDLE) && RST_N;
    assign write_bit_arg = tx_q;

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: two instances (CLK_PER_BIT 4 and 1) fed randomized bytes;
// a frame-level model predicts consume times and the line waveform cycle by cycle.
module tb_uart;

    localparam int NL = 2;

    typedef struct {
        int         start;
        logic [7:0] data;
    } frame_t;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic [8:0]    rbo [NL];
    logic [NL-1:0] rd;
    logic [NL-1:0] tx;
    logic [NL-1:0] wbo;

    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    int     phase = 0;
    int     bit3_cnt = 0;
    frame_t fq [NL][$];
    int     next_idle [NL];
    int     sidx [NL];
    logic [7:0] rx [NL];
    logic [7:0] akiok [5];

    uart #(.CLK_PER_BIT(4)) u_uart4 (
        .CLK(CLK), .RST_N(RST_N), .read_byte_out(rbo[0]), .read_byte_arg(rd[0]),
        .write_bit_out(wbo[0]), .write_bit_arg(tx[0])
    );

    uart #(.CLK_PER_BIT(1)) u_uart1 (
        .CLK(CLK), .RST_N(RST_N), .read_byte_out(rbo[1]), .read_byte_arg(rd[1]),
        .write_bit_out(wbo[1]), .write_bit_arg(tx[1])
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int cpb(input int l);
        return (l == 0) ? 4 : 1;
    endfunction

    // Line level in cycle c of a frame: start bit, data LSB first, stop bit.
    function automatic logic exp_line(input frame_t f, input int n, input int c);
        int k;
        logic [7:0] d;
        k = (c - f.start) / n;
        d = f.data;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        return 1'b1;
    endfunction

    task automatic check(input string name, input int lane, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s lane=%0d cyc=%0d actual=%0d expected=%0d", name, lane, cyc, act, exp);
        end
    endtask

    // Driver: chooses inputs each cycle and records every byte the model says is consumed.
    initial begin
        logic       idle;
        logic       v;
        logic [7:0] d;
        akiok[0] = 8'h61; akiok[1] = 8'h6b; akiok[2] = 8'h69; akiok[3] = 8'h6f; akiok[4] = 8'h6b;
        for (int l = 0; l < NL; l++) begin
            next_idle[l] = 0;
            sidx[l]      = 0;
            rbo[l]       = '0;
        end
        wbo = '0;
        forever begin
            @(negedge CLK);
            for (int l = 0; l < NL; l++) begin
                idle = RST_N && (cyc >= next_idle[l]);
                d    = 8'($urandom);
                v    = 1'($urandom);
                case (phase)
                    1: begin
                        v = 1'b1;
                        if (idle) d = (l == 0) ? 8'h61 : 8'hFF;
                    end
                    2: begin
                        v = (sidx[l] < 5);
                        if (idle && v) d = akiok[sidx[l]];
                    end
                    0, 3, 7: v = 1'b0;
                    default: ;
                endcase
                rbo[l] = {v, d};
                wbo[l] = 1'($urandom);
                if (!RST_N) begin
                    next_idle[l] = 0;
                end else if (idle && v) begin
                    fq[l].push_back('{start: cyc + 1, data: d});
                    next_idle[l] = cyc + 1 + 10 * cpb(l);
                    if (phase == 2) sidx[l]++;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the head of each lane's frame queue.
    initial begin
        frame_t f;
        int     n;
        int     off;
        int     k;
        logic   active;
        forever begin
            @(posedge CLK);
            #1;
            for (int l = 0; l < NL; l++) begin
                n = cpb(l);
                if (!RST_N) begin
                    check("reset_rd", l, int'(rd[l]), 0);
                    check("reset_tx", l, int'(tx[l]), 1);
                    fq[l].delete();
                end else begin
                    active = (fq[l].size() > 0) && (cyc >= fq[l][0].start);
                    check("rd", l, int'(rd[l]), int'(!active));
                    if (active) begin
                        f   = fq[l][0];
                        off = cyc - f.start;
                        k   = off / n;
                        check("tx", l, int'(tx[l]), int'(exp_line(f, n, cyc)));
                        if ((off % n == 0) && k >= 1 && k <= 8) rx[l][k-1] = tx[l];
                        if (l == 0 && k == 4 && (off % n) == 1) bit3_cnt++;
                        if (off == 10 * n - 1) begin
                            check("byte", l, int'(rx[l]), int'(f.data));
                            void'(fq[l].pop_front());
                        end
                    end else begin
                        check("tx_idle", l, int'(tx[l]), 1);
                    end
                end
            end
        end
    end

    // Sequencer: reset, directed frames, back-to-back string, idle, random, mid-frame reset.
    initial begin
        int base;
        int w;
        #1 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;
        phase = 1;
        repeat (90) @(posedge CLK);
        phase = 2;
        repeat (5 * 41 + 60) @(posedge CLK);
        phase = 3;
        repeat (20) @(posedge CLK);
        phase = 4;
        repeat (300) @(posedge CLK);
        phase = 5;
        base = bit3_cnt;
        w = 0;
        while (bit3_cnt == base && w < 500) begin
            @(posedge CLK);
            w++;
        end
        if (bit3_cnt == base) begin
            checks++;
            failures++;
            $display("FAIL bit3_wait lane=0 cyc=%0d actual=timeout expected=data_bit3", cyc);
        end else begin
            #2 RST_N = 1'b0;
            #1;
            for (int l = 0; l < NL; l++) begin
                check("async_rd", l, int'(rd[l]), 0);
                check("async_tx", l, int'(tx[l]), 1);
            end
            repeat (3) @(posedge CLK);
            #2 RST_N = 1'b1;
        end
        phase = 6;
        repeat (200) @(posedge CLK);
        phase = 7;
        repeat (60) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
